// File: rtl/control_loop_if.sv
// Channel bundle between the loop sequencer and its ADC reader, math block and DAC writer.
// Each channel is an arm/finished handshake; the sequencer is the master.
interface control_loop_if #(
    parameter int unsigned ADC_WID         = 18,
    parameter int unsigned ERR_WID         = 19,
    parameter int unsigned DAC_DATA_WID    = 20,
    parameter int unsigned CONSTS_WID      = 48,
    parameter int unsigned OUT_WHOLE       = 20,
    parameter int unsigned OUT_FRAC        = 40,
    parameter int unsigned CYCLE_COUNT_WID = 18
);
    localparam int unsigned OUT_WID = OUT_WHOLE + OUT_FRAC;

    logic                       adc_arm;
    logic                       adc_finished;
    logic [ADC_WID-1:0]         adc_data;

    logic                       math_arm;
    logic                       math_finished;
    logic [ADC_WID-1:0]         math_setpt;
    logic [ADC_WID-1:0]         math_measured;
    logic [CONSTS_WID-1:0]      math_cl_P;
    logic [CONSTS_WID-1:0]      math_cl_I;
    logic [CYCLE_COUNT_WID-1:0] math_cycles;
    logic [ERR_WID-1:0]         math_e_prev;
    logic [OUT_WID-1:0]         math_adjval_prev;
    logic [ERR_WID-1:0]         math_e_cur;
    logic [OUT_WID-1:0]         math_adj_val;

    logic                       dac_arm;
    logic                       dac_finished;
    logic [DAC_DATA_WID-1:0]    dac_data;

    modport master (
        output adc_arm,
        input  adc_finished, adc_data,
        output math_arm, math_setpt, math_measured, math_cl_P, math_cl_I,
        output math_cycles, math_e_prev, math_adjval_prev,
        input  math_finished, math_e_cur, math_adj_val,
        output dac_arm, dac_data,
        input  dac_finished
    );

    modport slave (
        input  adc_arm,
        output adc_finished, adc_data,
        input  math_arm, math_setpt, math_measured, math_cl_P, math_cl_I,
        input  math_cycles, math_e_prev, math_adjval_prev,
        output math_finished, math_e_cur, math_adj_val,
        input  dac_arm, dac_data,
        output dac_finished
    );
endinterface

// File: rtl/control_loop_sequencer.sv
// Control-loop initiator: per iteration reads the ADC, runs the math block with the
// retained loop state and elapsed-cycle count, then writes the saturated adjustment to the DAC.
module control_loop_sequencer #(
    parameter int unsigned ADC_WID         = 18,
    parameter int unsigned ERR_WID         = 19,
    parameter int unsigned DAC_DATA_WID    = 20,
    parameter int unsigned CONSTS_WID      = 48,
    parameter int unsigned OUT_WHOLE       = 20,
    parameter int unsigned OUT_FRAC        = 40,
    parameter int unsigned CYCLE_COUNT_WID = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [ADC_WID-1:0]    setpt_in,
    input  logic [CONSTS_WID-1:0] cl_P_in,
    input  logic [CONSTS_WID-1:0] cl_I_in,
    control_loop_if.master        bus,
    output logic                  running,
    output logic [31:0]           iter_count
);
    localparam int unsigned OUT_WID = OUT_WHOLE + OUT_FRAC;

    typedef enum logic [2:0] {
        IDLE, ADC_WAIT, ADC_DONE, MATH_WAIT, MATH_DONE, DAC_WAIT, DAC_DONE
    } state_t;

    state_t state, state_nxt;
    logic   adc_arm_nxt, math_arm_nxt, dac_arm_nxt;
    logic   latch_cfg, latch_meas, latch_cycles, latch_math, iter_inc;

    logic [CYCLE_COUNT_WID-1:0] cycle_cnt;
    logic [CYCLE_COUNT_WID-1:0] cycle_inc_c;
    logic [OUT_WHOLE-1:0]       adj_whole_c;
    logic [DAC_DATA_WID-1:0]    dac_sat_c;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Each arm rises only once its finished is low (covers stray finished) and the
    // state advances past a *_DONE state only after finished has returned low.
    always_comb begin
        state_nxt    = state;
        adc_arm_nxt  = bus.adc_arm;
        math_arm_nxt = bus.math_arm;
        dac_arm_nxt  = bus.dac_arm;
        latch_cfg    = 1'b0;
        latch_meas   = 1'b0;
        latch_cycles = 1'b0;
        latch_math   = 1'b0;
        iter_inc     = 1'b0;
        unique case (state)
            IDLE: if (run && !bus.adc_finished) begin
                adc_arm_nxt = 1'b1;
                latch_cfg   = 1'b1;
                state_nxt   = ADC_WAIT;
            end
            ADC_WAIT: if (bus.adc_finished) begin
                adc_arm_nxt = 1'b0;
                latch_meas  = 1'b1;
                state_nxt   = ADC_DONE;
            end
            ADC_DONE: if (!bus.adc_finished && !bus.math_finished) begin
                math_arm_nxt = 1'b1;
                latch_cycles = 1'b1;
                state_nxt    = MATH_WAIT;
            end
            MATH_WAIT: if (bus.math_finished) begin
                math_arm_nxt = 1'b0;
                latch_math   = 1'b1;
                state_nxt    = MATH_DONE;
            end
            MATH_DONE: if (!bus.math_finished && !bus.dac_finished) begin
                dac_arm_nxt = 1'b1;
                state_nxt   = DAC_WAIT;
            end
            DAC_WAIT: if (bus.dac_finished) begin
                dac_arm_nxt = 1'b0;
                iter_inc    = 1'b1;
                state_nxt   = DAC_DONE;
            end
            DAC_DONE: if (!bus.dac_finished) begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The latched count includes the entry edge itself, so it equals the clocks between math_arm rises.
    assign cycle_inc_c = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CYCLE_COUNT_WID'(1);

    always_ff @(posedge clk) begin
        if (rst || latch_cycles) cycle_cnt <= '0;
        else                     cycle_cnt <= cycle_inc_c;
    end

    // Whole part of the adjustment (floor), fitted to the DAC word.
    assign adj_whole_c = bus.math_adj_val[OUT_WID-1:OUT_FRAC];

    generate
        if (OUT_WHOLE > DAC_DATA_WID) begin : g_clamp
            logic [OUT_WHOLE-DAC_DATA_WID:0] upper_c;
            assign upper_c = adj_whole_c[OUT_WHOLE-1:DAC_DATA_WID-1];
            always_comb begin
                if (&upper_c || ~|upper_c)
                    dac_sat_c = adj_whole_c[DAC_DATA_WID-1:0];
                else if (adj_whole_c[OUT_WHOLE-1])
                    dac_sat_c = {1'b1, {(DAC_DATA_WID-1){1'b0}}};
                else
                    dac_sat_c = {1'b0, {(DAC_DATA_WID-1){1'b1}}};
            end
        end else if (OUT_WHOLE == DAC_DATA_WID) begin : g_pass
            assign dac_sat_c = adj_whole_c;
        end else begin : g_sext
            assign dac_sat_c = DAC_DATA_WID'($signed(adj_whole_c));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.adc_arm          <= 1'b0;
            bus.math_arm         <= 1'b0;
            bus.dac_arm          <= 1'b0;
            bus.math_setpt       <= '0;
            bus.math_measured    <= '0;
            bus.math_cl_P        <= '0;
            bus.math_cl_I        <= '0;
            bus.math_cycles      <= '0;
            bus.math_e_prev      <= '0;
            bus.math_adjval_prev <= '0;
            bus.dac_data         <= '0;
            running              <= 1'b0;
            iter_count           <= '0;
        end else begin
            bus.adc_arm  <= adc_arm_nxt;
            bus.math_arm <= math_arm_nxt;
            bus.dac_arm  <= dac_arm_nxt;
            running      <= (state_nxt != IDLE);
            if (latch_cfg) begin
                bus.math_setpt <= setpt_in;
                bus.math_cl_P  <= cl_P_in;
                bus.math_cl_I  <= cl_I_in;
            end
            if (latch_meas)   bus.math_measured <= bus.adc_data;
            if (latch_cycles) bus.math_cycles   <= cycle_inc_c;
            if (latch_math) begin
                bus.math_e_prev      <= bus.math_e_cur;
                bus.math_adjval_prev <= bus.math_adj_val;
                bus.dac_data         <= dac_sat_c;
            end
            if (iter_inc) iter_count <= iter_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_control_loop_sequencer.sv
// Directed bench for control_loop_sequencer with ADC/math/DAC responders that finish
// three cycles after arm; uses a 12-bit cycle counter so saturation is reachable quickly.
module tb_control_loop_sequencer;
    localparam int unsigned ADC_WID      = 18;
    localparam int unsigned ERR_WID      = 19;
    localparam int unsigned DAC_DATA_WID = 20;
    localparam int unsigned CONSTS_WID   = 48;
    localparam int unsigned OUT_WHOLE    = 20;
    localparam int unsigned OUT_FRAC     = 40;
    localparam int unsigned CCW          = 12;
    localparam int unsigned OUT_WID      = OUT_WHOLE + OUT_FRAC;

    logic                  clk, rst, run;
    logic [ADC_WID-1:0]    setpt_in;
    logic [CONSTS_WID-1:0] cl_P_in, cl_I_in;
    logic                  running;
    logic [31:0]           iter_count;

    control_loop_if #(
        .ADC_WID(ADC_WID), .ERR_WID(ERR_WID), .DAC_DATA_WID(DAC_DATA_WID),
        .CONSTS_WID(CONSTS_WID), .OUT_WHOLE(OUT_WHOLE), .OUT_FRAC(OUT_FRAC),
        .CYCLE_COUNT_WID(CCW)
    ) bus ();

    control_loop_sequencer #(
        .ADC_WID(ADC_WID), .ERR_WID(ERR_WID), .DAC_DATA_WID(DAC_DATA_WID),
        .CONSTS_WID(CONSTS_WID), .OUT_WHOLE(OUT_WHOLE), .OUT_FRAC(OUT_FRAC),
        .CYCLE_COUNT_WID(CCW)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .setpt_in(setpt_in),
        .cl_P_in(cl_P_in), .cl_I_in(cl_I_in), .bus(bus),
        .running(running), .iter_count(iter_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks, n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder controls and per-iteration return values.
    bit                  adc_hold, adc_stray;
    logic [ADC_WID-1:0]  adc_val;
    logic [ERR_WID-1:0]  e_cur_v;
    logic [OUT_WID-1:0]  adj_v;
    logic                fin_a, fin_m, fin_d;
    int                  cnt_a, cnt_m, cnt_d;
    bit                  rise;

    task automatic step(input logic arm, input bit hold, input bit stray,
                        inout logic fin, inout int cnt, output bit rose);
        rose = 1'b0;
        if (rst) begin
            fin = 1'b0;
            cnt = 0;
        end else if (stray) begin
            fin = 1'b1;
        end else if (fin) begin
            if (!arm) fin = 1'b0;
        end else if (arm && !hold) begin
            cnt++;
            if (cnt >= 3) begin
                fin  = 1'b1;
                cnt  = 0;
                rose = 1'b1;
            end
        end else begin
            cnt = 0;
        end
    endtask

    initial begin
        fin_a = 1'b0; fin_m = 1'b0; fin_d = 1'b0;
        cnt_a = 0; cnt_m = 0; cnt_d = 0;
        bus.adc_finished  = 1'b0;
        bus.adc_data      = '0;
        bus.math_finished = 1'b0;
        bus.math_e_cur    = '0;
        bus.math_adj_val  = '0;
        bus.dac_finished  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            step(bus.adc_arm, adc_hold, adc_stray, fin_a, cnt_a, rise);
            if (rise) bus.adc_data = adc_val;
            bus.adc_finished = fin_a;
            step(bus.math_arm, 1'b0, 1'b0, fin_m, cnt_m, rise);
            if (rise) begin
                bus.math_e_cur   = e_cur_v;
                bus.math_adj_val = adj_v;
            end
            bus.math_finished = fin_m;
            step(bus.dac_arm, 1'b0, 1'b0, fin_d, cnt_d, rise);
            bus.dac_finished = fin_d;
        end
    end

    function automatic logic arm_sel(input int sel);
        case (sel)
            0:       return bus.adc_arm;
            1:       return bus.math_arm;
            default: return bus.dac_arm;
        endcase
    endfunction

    task automatic wait_level(input int sel, input logic lvl, input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (arm_sel(sel) === lvl) ok = 1'b1;
        end
        check({tag, "_wait"}, 64'(ok), 64'(1));
    endtask

    // Directed iteration vectors: ADC sample, setpoint, math results, expected DAC word.
    logic [ADC_WID-1:0]      v_adc   [5];
    logic [ADC_WID-1:0]      v_setpt [5];
    logic [ERR_WID-1:0]      v_ecur  [5];
    logic [OUT_WID-1:0]      v_adj   [5];
    logic [DAC_DATA_WID-1:0] v_dac   [5];
    logic [ERR_WID-1:0]      exp_e_prev;
    logic [OUT_WID-1:0]      exp_adj_prev;
    int                      arm_cnt;

    initial begin
        v_adc[0] = 18'd100;   v_setpt[0] = 18'd50; v_ecur[0] = 19'h7FFCE;
        v_adj[0] = 60'h00005_0000000000; v_dac[0] = 20'h00005;
        v_adc[1] = 18'h3FFF9; v_setpt[1] = 18'd50; v_ecur[1] = 19'h00010;
        v_adj[1] = 60'hFFFFF_8000000000; v_dac[1] = 20'hFFFFF;
        v_adc[2] = 18'h1FFFF; v_setpt[2] = 18'd77; v_ecur[2] = 19'h3FFFF;
        v_adj[2] = 60'h00000_C000000000; v_dac[2] = 20'h00000;
        v_adc[3] = 18'h20000; v_setpt[3] = 18'd77; v_ecur[3] = 19'h40000;
        v_adj[3] = 60'h80000_0000000000; v_dac[3] = 20'h80000;
        v_adc[4] = 18'h00000; v_setpt[4] = 18'h3FFFF; v_ecur[4] = 19'h00123;
        v_adj[4] = 60'h7FFFF_FFFFFFFFFF; v_dac[4] = 20'h7FFFF;

        n_checks = 0; n_errors = 0;
        rst = 1'b1; run = 1'b0;
        setpt_in = v_setpt[0];
        cl_P_in  = 48'h01_8000000000;
        cl_I_in  = 48'h00_4000000000;
        adc_hold = 1'b0; adc_stray = 1'b0;
        adc_val  = v_adc[0];
        e_cur_v  = '0; adj_v = '0;
        exp_e_prev = '0; exp_adj_prev = '0;

        repeat (3) @(negedge clk);
        check("rst_adc_arm",  64'(bus.adc_arm),  64'(0));
        check("rst_math_arm", 64'(bus.math_arm), 64'(0));
        check("rst_dac_arm",  64'(bus.dac_arm),  64'(0));
        check("rst_running",  64'(running),      64'(0));
        check("rst_iter",     64'(iter_count),   64'(0));
        check("rst_dac_data", 64'(bus.dac_data), 64'(0));

        run = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("adc_arm_after_rst", 64'(bus.adc_arm), 64'(1));
        check("running_after_rst", 64'(running),     64'(1));

        // Continuous iterations through the vector table.
        for (int i = 0; i < 5; i++) begin
            wait_level(1, 1'b1, 40, "math_arm_rise");
            check("math_setpt",       64'(bus.math_setpt),       64'(v_setpt[i]));
            check("math_measured",    64'(bus.math_measured),    64'(v_adc[i]));
            check("math_e_prev",      64'(bus.math_e_prev),      64'(exp_e_prev));
            check("math_adjval_prev", 64'(bus.math_adjval_prev), 64'(exp_adj_prev));
            check("math_cycles",      64'(bus.math_cycles),      (i == 0) ? 64'(5) : 64'(13));
            if (i == 0) begin
                check("math_cl_P", 64'(bus.math_cl_P), 64'h01_8000000000);
                check("math_cl_I", 64'(bus.math_cl_I), 64'h00_4000000000);
            end
            e_cur_v = v_ecur[i];
            adj_v   = v_adj[i];
            wait_level(2, 1'b1, 40, "dac_arm_rise");
            check("dac_data", 64'(bus.dac_data), 64'(v_dac[i]));
            if (i < 4) begin
                adc_val  = v_adc[i+1];
                setpt_in = v_setpt[i+1];
            end
            wait_level(2, 1'b0, 40, "dac_arm_fall");
            check("iter_count", 64'(iter_count), 64'(i + 1));
            exp_e_prev   = v_ecur[i];
            exp_adj_prev = v_adj[i];
        end

        // run drops during MATH_WAIT: iteration still completes, then the block idles.
        adc_val = 18'h00042;
        wait_level(1, 1'b1, 40, "math_arm_rise_rd");
        run     = 1'b0;
        e_cur_v = 19'h7FF00;
        adj_v   = 60'h00003_0000000000;
        wait_level(2, 1'b1, 40, "dac_arm_rise_rd");
        check("dac_data_rd", 64'(bus.dac_data), 64'h3);
        wait_level(2, 1'b0, 40, "dac_arm_fall_rd");
        check("iter_count_rd", 64'(iter_count), 64'(6));
        arm_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.adc_arm) arm_cnt++;
        end
        check("no_adc_arm_idle", 64'(arm_cnt), 64'(0));
        check("running_idle",    64'(running), 64'(0));

        // A stray adc_finished holds off the arm until it clears.
        adc_stray = 1'b1;
        @(negedge clk);
        run = 1'b1;
        arm_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.adc_arm) arm_cnt++;
        end
        check("stray_blocks_arm", 64'(arm_cnt), 64'(0));
        adc_stray = 1'b0;
        @(negedge clk);
        check("arm_while_stray_clears", 64'(bus.adc_arm), 64'(0));
        @(negedge clk);
        check("arm_after_stray", 64'(bus.adc_arm), 64'(1));

        // Resume with retained loop state.
        wait_level(1, 1'b1, 40, "math_arm_rise_resume");
        check("resume_e_prev",      64'(bus.math_e_prev),      64'h7FF00);
        check("resume_adjval_prev", 64'(bus.math_adjval_prev), 64'h00003_0000000000);
        check("resume_measured",    64'(bus.math_measured),    64'h42);
        e_cur_v = 19'h00007;
        adj_v   = 60'h00001_0000000000;
        wait_level(2, 1'b1, 40, "dac_arm_rise_resume");
        adc_hold = 1'b1;
        wait_level(2, 1'b0, 40, "dac_arm_fall_resume");

        // Long ADC stall saturates the cycle counter.
        wait_level(0, 1'b1, 40, "adc_arm_rise_hold");
        repeat ((1 << CCW) + 10) @(negedge clk);
        check("adc_arm_held", 64'(bus.adc_arm), 64'(1));
        adc_hold = 1'b0;
        wait_level(1, 1'b1, 20, "math_arm_rise_sat");
        check("math_cycles_sat", 64'(bus.math_cycles), 64'hFFF);
        check("sat_e_prev",      64'(bus.math_e_prev), 64'h7);

        // Reset while in DAC_WAIT abandons the write and clears all state.
        wait_level(2, 1'b1, 40, "dac_arm_rise_rst");
        rst = 1'b1;
        @(negedge clk);
        check("rst2_adc_arm",  64'(bus.adc_arm),          64'(0));
        check("rst2_math_arm", 64'(bus.math_arm),         64'(0));
        check("rst2_dac_arm",  64'(bus.dac_arm),          64'(0));
        check("rst2_running",  64'(running),              64'(0));
        check("rst2_iter",     64'(iter_count),           64'(0));
        check("rst2_e_prev",   64'(bus.math_e_prev),      64'(0));
        check("rst2_adj_prev", 64'(bus.math_adjval_prev), 64'(0));
        check("rst2_cycles",   64'(bus.math_cycles),      64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst2_adc_arm_after", 64'(bus.adc_arm), 64'(1));
        wait_level(1, 1'b1, 40, "math_arm_rise_rst2");
        check("rst2_first_cycles", 64'(bus.math_cycles),   64'(5));
        check("rst2_first_e_prev", 64'(bus.math_e_prev),   64'(0));
        check("rst2_measured",     64'(bus.math_measured), 64'h42);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
